tone_sequencer: RTL and testbench
=================================

Name: tone_sequencer

Overview:
- Controller that plays a programmed note sequence on the 256-step sine LUT generator.
- Drives the generator's step-enable strobe (sin_clk) at a per-note rate and holds the generator in reset between notes, so every note starts at phase 0.
- Holds a small note table that a host writes, and sequences the entries in order, with optional looping, an inter-note gap and rest entries.
- Tone frequency = f_clk / (256 * (div+1)).

Parameters:
DEPTH, 16, number of note-table entries (power of two)
DIV_W, 16, width of the per-note divider field
DUR_W, 12, width of the per-note duration field (units: full 256-step sine periods)
GAP_CYCLES, 1024, silent clk cycles after each note; 0 = no gap
REST_DIV, 255, divider used to time rest entries

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; clock clk
cfg_we  in  1  note-table write strobe
cfg_addr  in  $clog2(DEPTH)  table write address
cfg_div  in  DIV_W  divider for the entry; 0 = rest
cfg_dur  in  DUR_W  duration in periods; 0 is treated as 1
seq_len  in  $clog2(DEPTH)+1  number of entries to play, 0..DEPTH
loop_en  in  1  after the last entry, restart at entry 0
start  in  1  single-cycle start request
stop  in  1  abort request
sin_clk  out  1  one-cycle step enable to the sine generator
sine_rst  out  1  reset to the sine generator
busy  out  1  high when not in IDLE
done  out  1  one-cycle pulse when a non-looping sequence completes
note_idx  out  $clog2(DEPTH)  index of the current entry
rest  out  1  high while a rest entry is timing

Behaviour:
- Reset values: sin_clk=0, sine_rst=1, busy=0, done=0, note_idx=0, rest=0. The FSM enters IDLE and all counters clear. Table contents are not cleared.
- Table write: a synchronous write on cfg_we is accepted in any state. A write to the active entry has no effect until that entry is next loaded.
- States:
  - IDLE: sine_rst=1. start with seq_len>0 -> LOAD, idx=0. start with seq_len=0 -> done pulses the next cycle and the FSM stays in IDLE.
  - LOAD: 1 cycle. Latches div/dur of entry idx into working registers, with dur=0 forced to 1. Clears div_cnt and step_cnt. sine_rst=1. rest = (div==0). -> PLAY.
  - PLAY:
    - div_cnt increments each cycle. When div_cnt == eff_div, where eff_div = REST_DIV for a rest entry and div otherwise, an internal strobe fires and div_cnt returns to 0.
    - sin_clk = strobe for a tone entry and 0 for a rest entry. sine_rst=0 for a tone entry and 1 for a rest entry.
    - The 8-bit step_cnt advances on each strobe and wraps 255->0. On each wrap, dur_cnt decrements.
    - The strobe that wraps step_cnt while dur_cnt==1 ends the note: -> GAP, or -> NEXT if GAP_CYCLES==0.
    - First strobe is on the (eff_div+1)th PLAY cycle. Note length is exactly dur*256*(eff_div+1) PLAY cycles.
  - GAP: sine_rst=1, sin_clk=0, for GAP_CYCLES cycles. -> NEXT.
  - NEXT: 1 cycle.
    - If idx < seq_len-1: idx+1 -> LOAD.
    - Else if loop_en: idx=0 -> LOAD.
    - Else: -> IDLE with done=1 for one cycle.
    - seq_len and loop_en are sampled here, so a change takes effect at the next boundary.
- stop (any non-IDLE state): -> IDLE next cycle. sin_clk=0 immediately, sine_rst=1, no done pulse. stop has priority over start and over the end-of-note transition in the same cycle.
- start while busy is ignored.
- seq_len > DEPTH is clamped to DEPTH.
- busy=0 exactly in IDLE. note_idx tracks idx in every state.
- Reset mid-sequence returns to the IDLE reset values on the next edge.

Test Plan:
- Entry0 = {div=3, dur=2}, seq_len=1, GAP_CYCLES=0, start -> LOAD 1 cycle, then 2048 PLAY cycles with a sin_clk every 4th cycle (512 strobes); done pulses exactly once, 2 cycles after the last strobe; busy falls with done.
- Entries {div=0, dur=1} and {div=1, dur=1}, seq_len=2 -> entry 0: rest=1, sine_rst=1, no sin_clk for 256*256 cycles, then GAP_CYCLES; entry 1: 256 strobes, one every 2nd cycle; note_idx goes 0 then 1.
- loop_en=1, seq_len=2, run 3 full passes -> note_idx sequence 0,1,0,1,0,1, no done pulse; deassert loop_en during entry 1 -> done after that entry.
- stop asserted on the 100th strobe of a note -> sin_clk never high after that cycle, sine_rst=1 and busy=0 the next cycle, no done; a new start replays from entry 0.
- start with seq_len=0 -> done the next cycle, busy never high. start while busy -> no restart; note_idx and counters unaffected.
- Entry with dur=0 -> same length as dur=1 (256 strobes). A cfg_we to the active entry during PLAY -> current note unchanged; the new values apply on the next loop pass. reset mid-PLAY -> all outputs at reset values.

Source files
------------

// File: rtl/tone_sequencer_if.sv
// Host-side bus of the tone sequencer: note-table programming, run control and status.
// The host drives through the master modport; the sequencer sits on the slave modport.
interface tone_sequencer_if #(
  parameter int DEPTH = 16,
  parameter int DIV_W = 16,
  parameter int DUR_W = 12
);
  localparam int AW = $clog2(DEPTH);

  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [DIV_W-1:0] cfg_div;
  logic [DUR_W-1:0] cfg_dur;
  logic [AW:0]      seq_len;
  logic             loop_en;
  logic             start;
  logic             stop;
  logic             busy;
  logic             done;
  logic [AW-1:0]    note_idx;

  modport master (
    output cfg_we, cfg_addr, cfg_div, cfg_dur, seq_len, loop_en, start, stop,
    input  busy, done, note_idx
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_div, cfg_dur, seq_len, loop_en, start, stop,
    output busy, done, note_idx
  );
endinterface

// File: rtl/tone_sequencer.sv
// Plays a host-programmed note table on a 256-step sine LUT generator by strobing its
// step enable at a per-note rate and holding it in reset between notes (phase 0 per note).
module tone_sequencer #(
  parameter int DEPTH      = 16,
  parameter int DIV_W      = 16,
  parameter int DUR_W      = 12,
  parameter int GAP_CYCLES = 1024,
  parameter int REST_DIV   = 255
) (
  input  logic             clk,
  input  logic             reset,
  tone_sequencer_if.slave  host,
  output logic             sin_clk_o,
  output logic             sine_rst_o,
  output logic             rest_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int GAP_W = $clog2(GAP_CYCLES + 2);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [DIV_W-1:0] REST_DIV_C = DIV_W'(REST_DIV);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PLAY = 3'd2,
    S_GAP  = 3'd3,
    S_NEXT = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] tbl_div_q [DEPTH];
  logic [DUR_W-1:0] tbl_dur_q [DEPTH];
  logic [AW-1:0]    idx_q, idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DUR_W-1:0] dur_cnt_q, dur_cnt_d;
  logic [7:0]       step_q, step_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             rest_q, rest_d;
  logic             done_q, done_d;

  logic [AW:0]      len_s;
  logic [DIV_W-1:0] eff_div_s;
  logic             strobe_s;
  logic             more_s;

  // Note table: host writes land in any state and are never cleared by reset.
  always_ff @(posedge clk) begin
    if (host.cfg_we) begin
      tbl_div_q[host.cfg_addr] <= host.cfg_div;
      tbl_dur_q[host.cfg_addr] <= host.cfg_dur;
    end
  end

  assign len_s     = (host.seq_len > DEPTH_C) ? DEPTH_C : host.seq_len;
  assign eff_div_s = rest_q ? REST_DIV_C : div_q;
  assign strobe_s  = (state_q == S_PLAY) && (div_cnt_q == eff_div_s);
  assign more_s    = (({1'b0, idx_q} + (AW + 1)'(1)) < len_s);

  // Next-state logic; a note ends on the strobe that wraps step 255->0 in its last period.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    div_d     = div_q;
    div_cnt_d = div_cnt_q;
    dur_cnt_d = dur_cnt_q;
    step_d    = step_q;
    gap_d     = gap_q;
    rest_d    = rest_q;
    done_d    = 1'b0;
    if (host.stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (host.start && !host.stop) begin
            if (len_s == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = S_LOAD;
              idx_d   = '0;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD: begin
          div_d     = tbl_div_q[idx_q];
          dur_cnt_d = (tbl_dur_q[idx_q] == '0) ? DUR_W'(1) : tbl_dur_q[idx_q];
          rest_d    = (tbl_div_q[idx_q] == '0);
          div_cnt_d = '0;
          step_d    = '0;
          gap_d     = '0;
          state_d   = S_PLAY;
        end
        S_PLAY: begin
          if (strobe_s) begin
            div_cnt_d = '0;
            step_d    = step_q + 8'd1;
            if (step_q == 8'hFF) begin
              if (dur_cnt_q == DUR_W'(1)) begin
                state_d = HAS_GAP ? S_GAP : S_NEXT;
              end else begin
                dur_cnt_d = dur_cnt_q - DUR_W'(1);
              end
            end else begin
              dur_cnt_d = dur_cnt_q;
            end
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_d = S_NEXT;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        S_NEXT: begin
          if (more_s) begin
            idx_d   = idx_q + AW'(1);
            state_d = S_LOAD;
          end else if (host.loop_en) begin
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and working registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      div_q     <= '0;
      div_cnt_q <= '0;
      dur_cnt_q <= '0;
      step_q    <= '0;
      gap_q     <= '0;
      rest_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      dur_cnt_q <= dur_cnt_d;
      step_q    <= step_d;
      gap_q     <= gap_d;
      rest_q    <= rest_d;
      done_q    <= done_d;
    end
  end

  // stop gates the step strobe in the same cycle so no step leaks out after an abort.
  assign sin_clk_o     = strobe_s && !rest_q && !host.stop;
  assign sine_rst_o    = !((state_q == S_PLAY) && !rest_q);
  assign rest_o        = (state_q == S_PLAY) && rest_q;
  assign host.busy     = (state_q != S_IDLE);
  assign host.done     = done_q;
  assign host.note_idx = idx_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: a timeline model of the note sequence checks every
// output on every cycle, and literal counts/latencies pin the model to the expected behaviour.
module tb_tone_sequencer;
  localparam int DEPTH = 16;
  localparam int DIV_W = 16;
  localparam int DUR_W = 12;
  localparam int GAP   = 6;
  localparam int RDIV  = 7;
  localparam int AW    = 4;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_PLAY = 2;
  localparam int M_GAP  = 3;
  localparam int M_NEXT = 4;

  logic clk = 1'b0;
  logic reset;
  logic sin_clk, sine_rst, rest;

  tone_sequencer_if #(.DEPTH(DEPTH), .DIV_W(DIV_W), .DUR_W(DUR_W)) hif ();

  tone_sequencer #(
    .DEPTH(DEPTH), .DIV_W(DIV_W), .DUR_W(DUR_W), .GAP_CYCLES(GAP), .REST_DIV(RDIV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .host(hif),
    .sin_clk_o(sin_clk),
    .sine_rst_o(sine_rst),
    .rest_o(rest)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // observed activity, cleared by the driver before each scenario
  int cyc = 0;
  int n_sin, n_done, n_busy, n_rest, n_sin_rest;
  int first_sin, last_sin, start_cyc, done_cyc;
  int idx_q[$];

  // model state
  int     m_mode = M_IDLE;
  longint m_t = 0;
  int     m_idx = 0, m_div = 0, m_dur = 1;
  bit     m_rest = 1'b0, m_done = 1'b0, m_ok = 1'b0;
  int     m_tdiv[DEPTH];
  int     m_tdur[DEPTH];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_obs();
    n_sin = 0; n_done = 0; n_busy = 0; n_rest = 0; n_sin_rest = 0;
    first_sin = -1; last_sin = -1; start_cyc = -1; done_cyc = -1;
    idx_q.delete();
  endtask

  task automatic wr(input int a, input int d, input int u);
    hif.cfg_we   = 1'b1;
    hif.cfg_addr = a[AW-1:0];
    hif.cfg_div  = d[DIV_W-1:0];
    hif.cfg_dur  = u[DUR_W-1:0];
    tick(1);
    hif.cfg_we   = 1'b0;
  endtask

  task automatic pulse_start();
    hif.start = 1'b1;
    tick(1);
    hif.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      tick(1);
      k++;
    end
    check({name, " done seen"}, (n_done > 0) ? 1 : 0, 1);
  endtask

  task automatic wait_idx_count(input int cnt, input int budget, input string name);
    int k = 0;
    while (idx_q.size() < cnt && k < budget) begin
      tick(1);
      k++;
    end
    check({name, " entries reached"}, idx_q.size(), cnt);
  endtask

  task automatic wait_sin_count(input int cnt, input int budget, input string name);
    int k = 0;
    while (n_sin < cnt && k < budget) begin
      tick(1);
      k++;
    end
    check({name, " strobes reached"}, n_sin, cnt);
  endtask

  function automatic int seq_code();
    int code = 0;
    foreach (idx_q[i]) code = code * 16 + idx_q[i];
    return code;
  endfunction

  // Per-cycle compare against the timeline model, then advance the model over the next edge.
  initial begin : monitor
    logic [8:0] act_v, exp_v;
    bit x_sin, x_srst, x_busy, x_rest, play, prev_busy;
    int e, len, prev_idx;
    longint note_len;
    prev_busy = 1'b0;
    prev_idx = 0;
    forever begin
      @(negedge clk);
      cyc++;
      e = m_rest ? RDIV : m_div;
      if (m_ok) begin
        play   = (m_mode == M_PLAY);
        x_sin  = play && !m_rest && !hif.stop && (((m_t + 1) % (e + 1)) == 0);
        x_srst = !(play && !m_rest);
        x_busy = (m_mode != M_IDLE);
        x_rest = play && m_rest;
        exp_v  = {x_sin, x_srst, x_busy, m_done, x_rest, m_idx[3:0]};
        act_v  = {sin_clk, sine_rst, hif.busy, hif.done, rest, hif.note_idx};
        check("cycle outputs {sin,srst,busy,done,rest,idx}", act_v, exp_v);
      end
      if (sin_clk === 1'b1) begin
        n_sin++;
        if (first_sin < 0) first_sin = cyc;
        last_sin = cyc;
        if (rest === 1'b1) n_sin_rest++;
      end
      if (hif.done === 1'b1) begin
        n_done++;
        done_cyc = cyc;
      end
      if (hif.busy === 1'b1) n_busy++;
      if (rest === 1'b1) n_rest++;
      if (hif.start === 1'b1) start_cyc = cyc;
      if (hif.busy === 1'b1 && (!prev_busy || int'(hif.note_idx) != prev_idx))
        idx_q.push_back(int'(hif.note_idx));
      prev_busy = (hif.busy === 1'b1);
      prev_idx = int'(hif.note_idx);

      len = (int'(hif.seq_len) > DEPTH) ? DEPTH : int'(hif.seq_len);
      if (reset) begin
        m_mode = M_IDLE; m_idx = 0; m_done = 1'b0; m_rest = 1'b0; m_t = 0; m_ok = 1'b1;
      end else if (m_ok) begin
        m_done = 1'b0;
        if (m_mode != M_IDLE && hif.stop) begin
          m_mode = M_IDLE;
        end else begin
          case (m_mode)
            M_IDLE: if (hif.start && !hif.stop) begin
              if (len == 0) m_done = 1'b1;
              else begin m_mode = M_LOAD; m_idx = 0; end
            end
            M_LOAD: begin
              m_div  = m_tdiv[m_idx];
              m_dur  = (m_tdur[m_idx] == 0) ? 1 : m_tdur[m_idx];
              m_rest = (m_div == 0);
              m_t    = 0;
              m_mode = M_PLAY;
            end
            M_PLAY: begin
              note_len = longint'(m_dur) * 256 * (e + 1);
              if (m_t == note_len - 1) begin
                m_t = 0;
                m_mode = (GAP > 0) ? M_GAP : M_NEXT;
              end else m_t++;
            end
            M_GAP: begin
              if (m_t == GAP - 1) begin m_t = 0; m_mode = M_NEXT; end
              else m_t++;
            end
            default: begin
              if (m_idx + 1 < len) begin m_idx++; m_mode = M_LOAD; end
              else if (hif.loop_en) begin m_idx = 0; m_mode = M_LOAD; end
              else begin m_mode = M_IDLE; m_done = 1'b1; end
            end
          endcase
        end
      end
      if (hif.cfg_we) begin
        m_tdiv[int'(hif.cfg_addr)] = int'(hif.cfg_div);
        m_tdur[int'(hif.cfg_addr)] = int'(hif.cfg_dur);
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : driver
    reset = 1'b1;
    hif.cfg_we = 1'b0; hif.cfg_addr = '0; hif.cfg_div = '0; hif.cfg_dur = '0;
    hif.seq_len = '0; hif.loop_en = 1'b0; hif.start = 1'b0; hif.stop = 1'b0;
    foreach (m_tdiv[i]) begin m_tdiv[i] = 0; m_tdur[i] = 0; end
    clear_obs();
    tick(3);
    check("reset busy", hif.busy, 0);
    check("reset sine_rst", sine_rst, 1);
    check("reset sin_clk", sin_clk, 0);
    check("reset done", hif.done, 0);
    check("reset note_idx", hif.note_idx, 0);
    check("reset rest", rest, 0);
    reset = 1'b0;
    tick(2);

    // single tone div=3 dur=2
    wr(0, 3, 2);
    hif.seq_len = 5'd1;
    clear_obs();
    pulse_start();
    wait_done(3000, "t1");
    tick(2);
    check("t1 strobes", n_sin, 512);
    check("t1 done count", n_done, 1);
    check("t1 first-to-last strobe", last_sin - first_sin, 2044);
    check("t1 start to first strobe", first_sin - start_cyc, 5);
    check("t1 last strobe to done", done_cyc - last_sin, GAP + 2);
    check("t1 start to done", done_cyc - start_cyc, 2057);

    // rest entry then a fast tone
    wr(0, 0, 1);
    wr(1, 1, 1);
    hif.seq_len = 5'd2;
    clear_obs();
    pulse_start();
    wait_done(5000, "t2");
    tick(2);
    check("t2 strobes during rest", n_sin_rest, 0);
    check("t2 rest cycles", n_rest, 256 * (RDIV + 1));
    check("t2 tone strobes", n_sin, 256);
    check("t2 idx sequence", seq_code(), 'h01);
    check("t2 done count", n_done, 1);

    // looping, three passes, then let it finish
    wr(0, 1, 1);
    wr(1, 2, 1);
    hif.seq_len = 5'd2;
    hif.loop_en = 1'b1;
    clear_obs();
    pulse_start();
    wait_idx_count(6, 6000, "t3");
    check("t3 no done while looping", n_done, 0);
    hif.loop_en = 1'b0;
    wait_done(3000, "t3");
    tick(2);
    check("t3 idx sequence", seq_code(), 'h010101);
    check("t3 idx entries", idx_q.size(), 6);
    check("t3 strobes", n_sin, 3 * 512);
    check("t3 done count", n_done, 1);

    // stop on the 100th strobe of entry 1, then replay from entry 0
    wr(0, 1, 1);
    wr(1, 1, 1);
    hif.seq_len = 5'd2;
    clear_obs();
    pulse_start();
    wait_sin_count(256 + 99, 3000, "t4");
    tick(1);
    hif.stop = 1'b1;
    tick(1);
    hif.stop = 1'b0;
    check("t4 busy after stop", hif.busy, 0);
    check("t4 sine_rst after stop", sine_rst, 1);
    tick(600);
    check("t4 strobes after stop", n_sin, 256 + 99);
    check("t4 no done on stop", n_done, 0);
    clear_obs();
    pulse_start();
    wait_done(3000, "t4 replay");
    tick(2);
    check("t4 replay idx sequence", seq_code(), 'h01);
    check("t4 replay strobes", n_sin, 512);

    // empty sequence, then a start while busy
    hif.seq_len = 5'd0;
    clear_obs();
    pulse_start();
    tick(3);
    check("t5 empty done count", n_done, 1);
    check("t5 empty done latency", done_cyc - start_cyc, 1);
    check("t5 empty busy cycles", n_busy, 0);
    wr(0, 2, 1);
    hif.seq_len = 5'd1;
    clear_obs();
    pulse_start();
    tick(50);
    pulse_start();
    wait_done(2000, "t5");
    tick(2);
    check("t5 strobes with extra start", n_sin, 256);
    check("t5 strobe span", last_sin - first_sin, 255 * 3);
    check("t5 done count", n_done, 1);

    // dur=0 behaves as dur=1
    wr(0, 1, 0);
    hif.seq_len = 5'd1;
    clear_obs();
    pulse_start();
    wait_done(2000, "t6");
    tick(2);
    check("t6 dur0 strobes", n_sin, 256);
    check("t6 dur0 span", last_sin - first_sin, 510);

    // rewrite the active entry: current note keeps div=1, next pass uses div=3
    wr(0, 1, 1);
    hif.loop_en = 1'b1;
    clear_obs();
    pulse_start();
    tick(20);
    wr(0, 3, 1);
    tick(800);
    hif.loop_en = 1'b0;
    wait_done(3000, "t6 rewrite");
    tick(2);
    check("t6 rewrite strobes", n_sin, 512);
    check("t6 rewrite start to done", done_cyc - start_cyc, 1553);

    // reset in the middle of a rest entry
    wr(0, 1, 1);
    wr(1, 0, 1);
    hif.seq_len = 5'd2;
    clear_obs();
    pulse_start();
    wait_idx_count(2, 2000, "t7");
    tick(50);
    check("t7 rest before reset", rest, 1);
    check("t7 idx before reset", hif.note_idx, 1);
    reset = 1'b1;
    tick(1);
    check("t7 reset busy", hif.busy, 0);
    check("t7 reset sine_rst", sine_rst, 1);
    check("t7 reset sin_clk", sin_clk, 0);
    check("t7 reset rest", rest, 0);
    check("t7 reset note_idx", hif.note_idx, 0);
    check("t7 reset done", hif.done, 0);
    reset = 1'b0;
    tick(5);
    check("t7 idle after reset", hif.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
